mrelbp_ci_joint_hist: RTL and testbench
=======================================

Name: mrelbp_ci_joint_hist

Overview:
- Downstream consumer of the R8 centre-intensity stage.
- Accumulates a per-frame joint histogram of the CI bit (ci_i) and the neighbour-intensity riu2 code (ni_i) into 2*(P+2) bins.
- At frame end, streams the bins out over a valid/ready handshake, then clears for the next frame.
- Feeds the feature-vector concatenation and classifier interface.

Parameters:
- P, 8, sampling points. The riu2 code range is 0..P+1, giving NBINS = 2*(P+2) = 20.
- CNT_W, 20, bin counter width. Covers 640x480 pixels without saturation.
- BIN_W, 5, bin index width. Must satisfy 2^BIN_W >= NBINS.

Ports:
- clk, in, 1, single system clock, rising edge.
- rst, in, 1, asynchronous active-low reset: 0 = reset, asserted asynchronously, released synchronously.
- done_i, in, 1, sample strobe; ci_i and ni_i are valid this cycle.
- ci_i, in, 1, centre-intensity bit from the CI stage.
- ni_i, in, 4, NI riu2 code, legal range 0..P+1.
- progress_done_i, in, 1, frame-end pulse. Any done_i sample in the same cycle belongs to the ending frame.
- hist_valid_o, out, 1, readout word valid.
- hist_ready_i, in, 1, readout consumer ready.
- hist_bin_o, out, BIN_W, bin index of the current word.
- hist_data_o, out, CNT_W, bin count.
- hist_last_o, out, 1, high with the final bin (NBINS-1).
- busy_o, out, 1, high in DRAIN, READOUT and CLEAR.
- err_o, out, 1, sticky: sample dropped or illegal code seen. Cleared only by reset.

Behaviour:
- Reset values: all bins 0, FSM in ACCUM, hist_valid_o=0, hist_bin_o=0, hist_data_o=0, hist_last_o=0, busy_o=0, err_o=0.
- Bin mapping: bin = ci_i*(P+2) + ni_i. Example: ci=1, ni=3 gives bin 13.
- Illegal code (ni_i > P+1): clamp to P+1 and set err_o.
- Pipeline:
  - Stage 1 registers {done_i, ci_i, clamped ni, progress_done_i}.
  - Stage 2 computes the bin index and increments that bin.
  - A sample strobed at cycle N is reflected in its bin at N+2.
  - Back-to-back samples to the same bin must each count; no hazard, since the increment is register-resident with one write per cycle.
- FSM states:
  - ACCUM: accept samples.
  - DRAIN: one cycle, stage 2 commits the last sample.
  - READOUT: stream bins 0..NBINS-1.
  - CLEAR: one cycle, zero all bins.
- Transitions:
  - ACCUM -> DRAIN when the stage-1 registered progress_done is seen.
  - DRAIN -> READOUT.
  - READOUT -> CLEAR on the handshake (valid && ready) with hist_last_o=1.
  - CLEAR -> ACCUM.
- Timing: a progress_done_i pulse at cycle N gives first hist_valid_o=1 at N+3.
- Readout handshake:
  - The word advances only on valid && ready.
  - hist_bin_o, hist_data_o and hist_last_o are held stable while valid && !ready.
  - hist_valid_o drops the cycle after the last handshake.
- Inputs outside ACCUM:
  - done_i in DRAIN/READOUT/CLEAR: sample discarded, err_o set.
  - progress_done_i in DRAIN/READOUT/CLEAR: ignored.
- Reset mid-operation (any state): immediate return to reset values. A partial readout is abandoned.
- Counter overflow: governed by the optional feature below.

Optional Feature:
- Macro: MRELBP_HIST_SAT_EN.
- Defined: bins saturate at 2^CNT_W-1 and further increments are held; a saturated bin also sets err_o.
- Undefined: bins wrap modulo 2^CNT_W and err_o is unaffected by overflow.

Decomposition:
- Shared package mrelbp_pkg holds:
  - MRELBP_P_R8 = 8
  - NBINS_R8 = 20
  - the FSM state encoding (ACCUM, DRAIN, READOUT, CLEAR)
  - the riu2 code width of 4
  - a function computing the joint bin index with clamping.
- One natural sub-module: mrelbp_bin_counter. It is a single CNT_W counter with inc, clr and saturation control, instantiated NBINS times in a generate loop.

Test Plan:
- Uniform fill: 20 samples covering each (ci, ni) pair once, then progress_done_i with hist_ready_i=1 -> 20 words, bins 0..19 each data=1, hist_last_o with bin 19, first valid 3 cycles after the frame end.
- Same-bin burst: 100 back-to-back samples ci=0, ni=9, with progress_done_i coincident with the 100th -> bin 9 = 100, all other bins 0, err_o=0.
- Backpressure: hist_ready_i toggling 1,0,0,1,... -> each bin is emitted exactly once with outputs stable during stalls; the next frame then reads all zeros after CLEAR.
- Illegal code and drop: ni_i=12 with ci_i=1 -> bin 19 increments and err_o=1; a done_i during READOUT is discarded and the bin counts are unchanged.
- Overflow at CNT_W=4: 17 hits on bin 0 -> data=15 with MRELBP_HIST_SAT_EN defined, data=1 without it.
- Reset mid-readout: drive rst=0 after bin 5 -> hist_valid_o=0 immediately; a following frame with 3 samples in bin 2 reads bin 2 = 3 and all others 0.

Source files
------------

// File: rtl/mrelbp_pkg.sv
// Shared MR-ELBP definitions: R8 geometry, riu2 code width, joint-histogram FSM
// state encoding, and helpers for clamping codes and forming joint bin indices.
package mrelbp_pkg;

  localparam int MRELBP_P_R8 = 8;
  localparam int NBINS_R8    = 20;
  localparam int RIU2_W      = 4;

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    DRAIN   = 2'd1,
    READOUT = 2'd2,
    CLEAR   = 2'd3
  } hist_state_t;

  // Codes above P+1 cannot come from a legal riu2 mapping; pin them to the top code.
  function automatic logic [RIU2_W-1:0] riu2_clamp(input logic [RIU2_W-1:0] ni, input int p);
    logic [RIU2_W-1:0] lim;
    lim = RIU2_W'(p + 1);
    return (ni > lim) ? lim : ni;
  endfunction

  function automatic int joint_bin(input logic ci, input logic [RIU2_W-1:0] ni, input int p);
    return (ci ? p + 2 : 0) + int'(ni);
  endfunction

endpackage

// File: rtl/mrelbp_ci_joint_hist_if.sv
// Readout stream of the CI/NI joint histogram: one bin per valid/ready handshake.
interface mrelbp_ci_joint_hist_if #(
  parameter int CNT_W = 20,
  parameter int BIN_W = 5
);
  logic             hist_valid_o;
  logic             hist_ready_i;
  logic [BIN_W-1:0] hist_bin_o;
  logic [CNT_W-1:0] hist_data_o;
  logic             hist_last_o;

  modport master (output hist_valid_o, hist_bin_o, hist_data_o, hist_last_o,
                  input  hist_ready_i);
  modport slave  (input  hist_valid_o, hist_bin_o, hist_data_o, hist_last_o,
                  output hist_ready_i);
endinterface

// File: rtl/mrelbp_bin_counter.sv
// One histogram bin: CNT_W counter with increment and clear.
// MRELBP_HIST_SAT_EN selects saturation (flagged on sat_hit) instead of wrap-around.
module mrelbp_bin_counter #(
  parameter int CNT_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             sat_hit
);

`ifdef MRELBP_HIST_SAT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

  assign sat_hit = inc && (cnt == CNT_MAX);
`else
  function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] c);
    return c + 1'b1;
  endfunction

  assign sat_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (inc)
      cnt <= cnt_step(cnt);
  end

endmodule

// File: rtl/mrelbp_ci_joint_hist.sv
// Per-frame joint histogram of CI bit and NI riu2 code with handshake readout.
// Optional macro MRELBP_HIST_SAT_EN: bins saturate (and flag err_o) instead of wrapping.
module mrelbp_ci_joint_hist
  import mrelbp_pkg::*;
#(
  parameter int P     = MRELBP_P_R8,
  parameter int CNT_W = 20,
  parameter int BIN_W = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    done_i,
  input  logic                    ci_i,
  input  logic [RIU2_W-1:0]       ni_i,
  input  logic                    progress_done_i,
  mrelbp_ci_joint_hist_if.master  hist,
  output logic                    busy_o,
  output logic                    err_o
);

  localparam int NBINS = 2 * (P + 2);

  hist_state_t       state, state_nxt;
  logic              vld_p1, ci_p1, pd_p1;
  logic [RIU2_W-1:0] ni_p1;
  logic [BIN_W-1:0]  bin_p1, rd_idx;
  logic [CNT_W-1:0]  cnt [NBINS];
  logic [NBINS-1:0]  inc, sat_hit;
  logic              accept, illegal, dropped, hs, rd_last, clear;

  assign accept  = done_i && (state == ACCUM);
  assign dropped = done_i && (state != ACCUM);
  assign illegal = done_i && (riu2_clamp(ni_i, P) != ni_i);

  // Stage 1: register the sample and frame-end strobe, code already clamped
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1 <= 1'b0;
      ci_p1  <= 1'b0;
      ni_p1  <= '0;
      pd_p1  <= 1'b0;
    end else begin
      vld_p1 <= accept;
      ci_p1  <= ci_i;
      ni_p1  <= riu2_clamp(ni_i, P);
      pd_p1  <= progress_done_i && (state == ACCUM);
    end
  end

  // Stage 2: one-hot increment of the addressed bin, committed in the counter register
  assign bin_p1 = BIN_W'(joint_bin(ci_p1, ni_p1, P));
  assign clear  = (state == CLEAR);

  always_comb begin
    inc = '0;
    if (vld_p1)
      inc[bin_p1] = 1'b1;
  end

  for (genvar b = 0; b < NBINS; b++) begin : g_bin
    mrelbp_bin_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .inc     (inc[b]),
      .clr     (clear),
      .cnt     (cnt[b]),
      .sat_hit (sat_hit[b])
    );
  end

  assign hs      = hist.hist_valid_o && hist.hist_ready_i;
  assign rd_last = (rd_idx == BIN_W'(NBINS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ACCUM;
      rd_idx <= '0;
      err_o  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (hs)
        rd_idx <= rd_last ? '0 : rd_idx + 1'b1;
      if (illegal || dropped || (|sat_hit))
        err_o <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (pd_p1) state_nxt = DRAIN;
      DRAIN:   state_nxt = READOUT;
      READOUT: if (hs && rd_last) state_nxt = CLEAR;
      CLEAR:   state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  // Readout word is a pure function of rd_idx and frozen bins, so it holds while stalled
  always_comb begin
    hist.hist_valid_o = (state == READOUT);
    hist.hist_bin_o   = '0;
    hist.hist_data_o  = '0;
    hist.hist_last_o  = 1'b0;
    if (state == READOUT) begin
      hist.hist_bin_o  = rd_idx;
      hist.hist_data_o = cnt[rd_idx];
      hist.hist_last_o = rd_last;
    end
  end

  assign busy_o = (state != ACCUM);

endmodule

// File: tb/tb_mrelbp_ci_joint_hist.sv
// Bench for mrelbp_ci_joint_hist: table-driven samples, scoreboarded readout words.
module tb_mrelbp_ci_joint_hist;
  import mrelbp_pkg::*;

  typedef struct {
    logic       ci;
    logic [3:0] ni;
    int         bin;
  } vec_t;

  typedef struct {
    int bin;
    int data;
    bit last;
  } word_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       done_i, ci_i, progress_done_i, rdy;
  logic [3:0] ni_i;
  logic       busy, err, busy4, err4;

  mrelbp_ci_joint_hist_if #(.CNT_W(20), .BIN_W(5)) hif ();
  mrelbp_ci_joint_hist_if #(.CNT_W(4),  .BIN_W(5)) hif4 ();
  assign hif.hist_ready_i  = rdy;
  assign hif4.hist_ready_i = rdy;

  mrelbp_ci_joint_hist #(.P(8), .CNT_W(20), .BIN_W(5)) dut (
    .clk(clk), .rst(rst_n), .done_i(done_i), .ci_i(ci_i), .ni_i(ni_i),
    .progress_done_i(progress_done_i), .hist(hif.master), .busy_o(busy), .err_o(err));

  mrelbp_ci_joint_hist #(.P(8), .CNT_W(4), .BIN_W(5)) dut4 (
    .clk(clk), .rst(rst_n), .done_i(done_i), .ci_i(ci_i), .ni_i(ni_i),
    .progress_done_i(progress_done_i), .hist(hif4.master), .busy_o(busy4), .err_o(err4));

  always #5 clk = ~clk;

  int    n_vec = 0, n_err = 0;
  int    cyc = 0, pd_cyc = 0;
  int    model [20];
  word_t sb [$];
  bit    accum_phase = 1'b1, lat_chk = 1'b0, chk4 = 1'b0;
  int    exp4, experr4;
  vec_t  tbl [$];
  vec_t  ill [4];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  initial forever @(posedge clk) cyc++;

  // Readout monitor: pops the scoreboard on each handshake and checks stall stability
  initial begin
    bit held_v;
    int held_bin, held_data;
    bit held_last;
    word_t w;
    held_v = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && hif.hist_valid_o) begin
        if (lat_chk) begin
          chk("first_valid_latency", cyc - pd_cyc, 3);
          lat_chk = 1'b0;
        end
        chk("busy_in_readout", busy, 1);
        if (held_v) begin
          chk("stall_bin", hif.hist_bin_o, held_bin);
          chk("stall_data", hif.hist_data_o, held_data);
          chk("stall_last", hif.hist_last_o, held_last);
        end
        if (hif.hist_ready_i) begin
          if (sb.size() == 0) begin
            chk("unexpected_word_bin", hif.hist_bin_o, -1);
          end else begin
            w = sb.pop_front();
            chk("word_bin", hif.hist_bin_o, w.bin);
            chk($sformatf("word_data_bin%0d", w.bin), hif.hist_data_o, w.data);
            chk($sformatf("word_last_bin%0d", w.bin), hif.hist_last_o, w.last);
          end
        end
        held_v    = !hif.hist_ready_i;
        held_bin  = hif.hist_bin_o;
        held_data = hif.hist_data_o;
        held_last = hif.hist_last_o;
      end else begin
        held_v = 1'b0;
      end
      if (chk4 && hif4.hist_valid_o && hif4.hist_ready_i && hif4.hist_bin_o == 5'd0) begin
        chk("cnt4_overflow_bin0", hif4.hist_data_o, exp4);
        chk4 = 1'b0;
      end
    end
  end

  task automatic drive(input logic d, input logic c, input logic [3:0] n, input logic pd,
                       input int bin);
    @(posedge clk); #1;
    done_i = d; ci_i = c; ni_i = n; progress_done_i = pd;
    if (d && accum_phase) model[bin]++;
    if (pd && accum_phase) begin
      for (int b = 0; b < 20; b++) begin
        sb.push_back('{b, model[b], b == 19});
        model[b] = 0;
      end
      accum_phase = 1'b0;
      pd_cyc      = cyc;
      lat_chk     = 1'b1;
    end
  endtask

  task automatic readout(input int mode, input int drop_at);
    int k = 0;
    while (sb.size() > 0 && k < 400) begin
      @(posedge clk); #1;
      rdy = (mode == 0) ? 1'b1 : (k % 3 == 0);
      done_i = (k == drop_at); ci_i = 1'b0; ni_i = 4'd0; progress_done_i = 1'b0;
      k++;
    end
    if (sb.size() > 0) begin
      chk("readout_timeout_pending", sb.size(), 0);
      sb.delete();
    end
    @(posedge clk); #1;
    done_i = 1'b0; rdy = 1'b1;
    @(posedge clk); #1;
    accum_phase = 1'b1;
    lat_chk     = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    sb.delete();
    for (int b = 0; b < 20; b++) model[b] = 0;
    accum_phase = 1'b1;
    lat_chk     = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int seen;
    for (int c = 0; c < 2; c++)
      for (int n = 0; n < 10; n++)
        tbl.push_back('{c[0], 4'(n), c * 10 + n});
    ill[0] = '{1'b1, 4'd12, 19};
    ill[1] = '{1'b0, 4'd15, 9};
    ill[2] = '{1'b1, 4'd10, 19};
    ill[3] = '{1'b0, 4'd11, 9};
`ifdef MRELBP_HIST_SAT_EN
    exp4 = 15; experr4 = 1;
`else
    exp4 = 1;  experr4 = 0;
`endif
    for (int b = 0; b < 20; b++) model[b] = 0;
    done_i = 0; ci_i = 0; ni_i = 0; progress_done_i = 0; rdy = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", hif.hist_valid_o, 0);
    chk("rst_bin", hif.hist_bin_o, 0);
    chk("rst_data", hif.hist_data_o, 0);
    chk("rst_last", hif.hist_last_o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;

    // Uniform fill: every (ci, ni) pair once
    foreach (tbl[i]) drive(1'b1, tbl[i].ci, tbl[i].ni, 1'b0, tbl[i].bin);
    drive(1'b0, 1'b0, 4'd0, 1'b1, 0);
    readout(0, -1);
    chk("uniform_err", err, 0);

    // Same-bin burst with frame end on the last sample
    for (int i = 0; i < 100; i++) drive(1'b1, 1'b0, 4'd9, i == 99, 9);
    readout(0, -1);
    chk("burst_err", err, 0);

    // Backpressure with a sample dropped during readout
    drive(1'b1, 1'b1, 4'd0, 1'b0, 10);
    drive(1'b1, 1'b0, 4'd5, 1'b0, 5);
    drive(1'b1, 1'b1, 4'd5, 1'b0, 15);
    drive(1'b1, 1'b1, 4'd5, 1'b0, 15);
    drive(1'b0, 1'b0, 4'd0, 1'b1, 0);
    readout(1, 5);
    chk("drop_err", err, 1);

    // Empty frame after CLEAR reads all zeros
    drive(1'b0, 1'b0, 4'd0, 1'b1, 0);
    readout(1, -1);

    do_reset();
    chk("reset_clears_err", err, 0);

    // Illegal codes clamp to the top code of their half
    foreach (ill[i]) drive(1'b1, ill[i].ci, ill[i].ni, 1'b0, ill[i].bin);
    drive(1'b0, 1'b0, 4'd0, 1'b1, 0);
    readout(0, -1);
    chk("illegal_err", err, 1);

    do_reset();

    // Overflow on the CNT_W=4 instance
    chk4 = 1'b1;
    for (int i = 0; i < 17; i++) drive(1'b1, 1'b0, 4'd0, 1'b0, 0);
    drive(1'b0, 1'b0, 4'd0, 1'b1, 0);
    readout(0, -1);
    chk("cnt4_bin0_seen", chk4, 0);
    chk("cnt4_err", err4, experr4);
    chk("cnt20_err_no_overflow", err, 0);

    // Reset in the middle of a readout
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 4'(i), 1'b0, i);
    drive(1'b0, 1'b0, 4'd0, 1'b1, 0);
    drive(1'b0, 1'b0, 4'd0, 1'b0, 0);
    seen = 0;
    for (int i = 0; i < 50 && seen == 0; i++) begin
      @(negedge clk);
      if (hif.hist_valid_o && hif.hist_bin_o == 5'd5) seen = 1;
    end
    chk("midrst_reached_bin5", seen, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", hif.hist_valid_o, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_busy4", busy4, 0);
    chk("midrst_bin", hif.hist_bin_o, 0);
    sb.delete();
    for (int b = 0; b < 20; b++) model[b] = 0;
    accum_phase = 1'b1;
    lat_chk     = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 4'd2, 1'b0, 2);
    drive(1'b0, 1'b0, 4'd0, 1'b1, 0);
    readout(0, -1);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
